// File: rtl/sync_filter_edge.sv
// Multi-channel input conditioner: flop-chain synchroniser, per-channel
// stability filter and registered one-cycle rise/fall pulse generation.
module sync_filter_edge #(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      STAGES   = 2,
    parameter int unsigned      FILT_CNT = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change
);
    localparam logic [4:0] FILT_LIM = 5'(FILT_CNT);

    logic [WIDTH-1:0] stage_r   [STAGES];
    logic [3:0]       cnt_r     [WIDTH];
    logic [3:0]       cnt_nxt_s [WIDTH];
    logic [4:0]       inc_s     [WIDTH];
    logic [WIDTH-1:0] filt_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] commit_s;
    logic [WIDTH-1:0] sync_s;

    assign sync_s = stage_r[STAGES-1];

    // Per-channel run counter; a run of FILT_CNT differing samples commits.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            inc_s[i]     = {1'b0, cnt_r[i]} + 5'd1;
            commit_s[i]  = 1'b0;
            cnt_nxt_s[i] = 4'd0;
            if (sync_s[i] == filt_r[i]) begin
                cnt_nxt_s[i] = 4'd0;
            end else if (inc_s[i] >= FILT_LIM) begin
                commit_s[i]  = 1'b1;
                cnt_nxt_s[i] = 4'd0;
            end else begin
                cnt_nxt_s[i] = inc_s[i][3:0];
            end
        end
    end

    // Synchroniser chain, committed level, run counters and pulse registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= RST_VAL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= 4'd0;
            end
            filt_r <= RST_VAL;
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
        end else begin
            stage_r[0] <= async_in;
            for (int k = 1; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            // A commit only happens where sync differs, so toggling adopts sync.
            filt_r <= filt_r ^ commit_s;
            rise_r <= commit_s & sync_s;
            fall_r <= commit_s & ~sync_s;
        end
    end

    assign sync_out   = sync_s;
    assign filt_out   = filt_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign change     = |(rise_r | fall_r);

endmodule

// File: tb/tb_sync_filter_edge.sv
// Scoreboard bench for sync_filter_edge: default instance plus a
// STAGES=4 / FILT_CNT=1 / RST_VAL=4'hA instance driven side by side.
module tb_sync_filter_edge;
    logic       clk;
    logic       n_rst;
    logic [3:0] in_a, in_b;
    logic [3:0] sync_a, filt_a, rise_a, fall_a;
    logic [3:0] sync_b, filt_b, rise_b, fall_b;
    logic       chg_a, chg_b;
    int         total;
    int         bad;

    typedef struct packed {
        logic [3:0] sa, fa, ra, la;
        logic       ca;
        logic [3:0] sb, fb, rb, lb;
        logic       cb;
    } exp_t;

    exp_t       sb_q [$];
    logic [3:0] m_st   [2][4];
    int         m_run  [2][4];
    logic [3:0] m_filt [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];

    sync_filter_edge u_dut_a (
        .clk(clk), .n_rst(n_rst), .async_in(in_a), .sync_out(sync_a),
        .filt_out(filt_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .change(chg_a)
    );

    sync_filter_edge #(.WIDTH(4), .STAGES(4), .FILT_CNT(1), .RST_VAL(4'hA)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .async_in(in_b), .sync_out(sync_b),
        .filt_out(filt_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .change(chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one instance across a single rising edge.
    task automatic model_edge(input int m, input logic rst, input logic [3:0] din);
        int         stg = (m == 0) ? 2 : 4;
        int         fc  = (m == 0) ? 3 : 1;
        logic [3:0] rv  = (m == 0) ? 4'h0 : 4'hA;
        logic [3:0] s;
        if (!rst) begin
            for (int k = 0; k < 4; k++) m_st[m][k] = rv;
            for (int c = 0; c < 4; c++) m_run[m][c] = 0;
            m_filt[m] = rv;
            m_rise[m] = 4'h0;
            m_fall[m] = 4'h0;
        end else begin
            s = m_st[m][stg-1];
            m_rise[m] = 4'h0;
            m_fall[m] = 4'h0;
            for (int c = 0; c < 4; c++) begin
                if (s[c] != m_filt[m][c]) begin
                    m_run[m][c]++;
                    if (m_run[m][c] == fc) begin
                        m_filt[m][c] = s[c];
                        if (s[c]) m_rise[m][c] = 1'b1;
                        else      m_fall[m][c] = 1'b1;
                        m_run[m][c] = 0;
                    end
                end else begin
                    m_run[m][c] = 0;
                end
            end
            for (int k = 3; k > 0; k--) m_st[m][k] = m_st[m][k-1];
            m_st[m][0] = din;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        exp_t got_e;
        n_rst = r;
        in_a  = a;
        in_b  = b;
        model_edge(0, r, a);
        model_edge(1, r, b);
        e.sa = m_st[0][1];  e.fa = m_filt[0]; e.ra = m_rise[0]; e.la = m_fall[0];
        e.ca = |(m_rise[0] | m_fall[0]);
        e.sb = m_st[1][3];  e.fb = m_filt[1]; e.rb = m_rise[1]; e.lb = m_fall[1];
        e.cb = |(m_rise[1] | m_fall[1]);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        check_val("sync_a", sync_a, got_e.sa);
        check_val("filt_a", filt_a, got_e.fa);
        check_val("rise_a", rise_a, got_e.ra);
        check_val("fall_a", fall_a, got_e.la);
        check_val("chg_a", {3'b000, chg_a}, {3'b000, got_e.ca});
        check_val("sync_b", sync_b, got_e.sb);
        check_val("filt_b", filt_b, got_e.fb);
        check_val("rise_b", rise_b, got_e.rb);
        check_val("fall_b", fall_b, got_e.lb);
        check_val("chg_b", {3'b000, chg_b}, {3'b000, got_e.cb});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_rst = 1'b0;
        in_a  = 4'h0;
        in_b  = 4'hA;

        // Reset held two cycles with inputs at all-ones.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'hF, 4'hA);
            check_val("rst_sync_a", sync_a, 4'h0);
            check_val("rst_filt_a", filt_a, 4'h0);
            check_val("rst_pulse_a", rise_a | fall_a, 4'h0);
            check_val("rst_chg_a", {3'b000, chg_a}, 4'h0);
            check_val("rst_sync_b", sync_b, 4'hA);
            check_val("rst_filt_b", filt_b, 4'hA);
        end

        // Release: A commits F on the 5th edge; B sees ch0 rise / ch1 fall on the 5th.
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 4'hF, 4'h9);
            if (i < 5) begin
                check_val("rel_early_a", rise_a, 4'h0);
            end else if (i == 5) begin
                check_val("rel_rise_a", rise_a, 4'hF);
                check_val("sweep_rise_b", rise_b, 4'b0001);
                check_val("sweep_fall_b", fall_b, 4'b0010);
                check_val("sweep_filt_b", filt_b, 4'h9);
            end else begin
                check_val("rel_late_a", rise_a, 4'h0);
            end
        end

        for (int i = 0; i < 8; i++) step(1'b1, 4'h0, 4'h9);

        // Clean rise on ch0.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'b0001, 4'h9);
            if (i == 2) check_val("cr_sync", sync_a, 4'b0001);
            if (i == 4) check_val("cr_early", rise_a, 4'h0);
            if (i == 5) begin
                check_val("cr_rise", rise_a, 4'b0001);
                check_val("cr_filt", filt_a, 4'b0001);
                check_val("cr_chg", {3'b000, chg_a}, 4'h1);
            end
            if (i == 6) check_val("cr_after", rise_a, 4'h0);
        end

        // Two-cycle glitch on ch1 is discarded.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, (i <= 2) ? 4'b0011 : 4'b0001, 4'h9);
            check_val("gl_filt", filt_a, 4'b0001);
            check_val("gl_chg", {3'b000, chg_a}, 4'h0);
        end

        // Three-cycle pulse on ch1 is accepted: rise then fall three cycles apart.
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, (i <= 3) ? 4'b0011 : 4'b0001, 4'h9);
            if (i == 5) check_val("p3_rise", rise_a, 4'b0010);
            if (i == 8) check_val("p3_fall", fall_a, 4'b0010);
        end

        for (int i = 0; i < 8; i++) step(1'b1, 4'b0100, 4'h9);
        check_val("sim_pre", filt_a, 4'b0100);

        // Simultaneous fall on ch2 and rise on ch3.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'b1000, 4'h9);
            if (i == 5) begin
                check_val("sim_fall", fall_a, 4'b0100);
                check_val("sim_rise", rise_a, 4'b1000);
                check_val("sim_chg", {3'b000, chg_a}, 4'h1);
            end
            if (i == 6) check_val("sim_chg_off", {3'b000, chg_a}, 4'h0);
        end

        for (int i = 0; i < 8; i++) step(1'b1, 4'h0, 4'h9);

        // Reset lands on the edge where the ch0 count would reach 2.
        for (int i = 1; i <= 4; i++) begin
            step((i == 4) ? 1'b0 : 1'b1, 4'b0001, 4'h9);
            check_val("rmf_rise", rise_a, 4'h0);
        end
        check_val("rmf_filt", filt_a, 4'h0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 4'b0001, 4'h9);
            if (i < 5) check_val("rmf_hold", filt_a, 4'h0);
            if (i == 5) check_val("rmf_commit", rise_a, 4'b0001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_filter_edge.md
# sync_filter_edge

Parametrised multi-channel input conditioner, successor to the single-bit reset-low synchroniser. Each of WIDTH asynchronous inputs passes through a configurable-depth flop chain. A per-channel stability filter follows, then an edge detector that emits one-cycle rise/fall pulses. It sits at the chip-pin boundary ahead of any FSM that consumes buttons, handshake strobes or external status lines.

## Interface
- WIDTH, 4: number of independent channels, 1..32
- STAGES, 2: synchroniser flop depth, 2..4
- FILT_CNT, 3: consecutive differing synchronised samples required to commit a new level, 1..15
- RST_VAL, {WIDTH{1'b0}}: per-channel reset level of the sync chain and the filtered output
- clk  input  1  system clock; all state updates on its rising edge
- n_rst  input  1  reset, synchronous, active-low
- async_in  input  WIDTH  asynchronous raw inputs
- sync_out  output  WIDTH  raw synchronised value (last chain stage)
- filt_out  output  WIDTH  filtered, committed level per channel
- rise_pulse  output  WIDTH  one-cycle pulse when filt_out commits 0->1
- fall_pulse  output  WIDTH  one-cycle pulse when filt_out commits 1->0
- change  output  1  OR-reduction of rise_pulse | fall_pulse (combinational from registered pulses)

## Operation
- Synchroniser: stage[0] <= async_in; stage[k] <= stage[k-1]; sync_out = stage[STAGES-1]. No logic between stages.
- Filter, per channel, 4-bit counter cnt:
  - sync_out == filt_out: cnt <= 0.
  - sync_out != filt_out and cnt+1 < FILT_CNT: cnt <= cnt+1.
  - sync_out != filt_out and cnt+1 == FILT_CNT: filt_out <= sync_out, cnt <= 0, and the matching rise/fall pulse is registered in the same edge.
- The counter never exceeds FILT_CNT-1. It does not wrap.
- A level that differs from filt_out for fewer than FILT_CNT consecutive sync_out cycles is discarded: cnt clears, and there is no output change and no pulse.
- FILT_CNT=1 disables filtering. filt_out follows sync_out one cycle later.
- rise_pulse/fall_pulse are registered, high for exactly one cycle, and deassert the following cycle unless the channel commits again. A given channel cannot commit on consecutive cycles when FILT_CNT>1.
- Channels are fully independent. Simultaneous commits on several channels assert all corresponding pulse bits in the same cycle, and change is high for that one cycle.
- Reset (n_rst low at a rising edge):
  - All chain stages <= RST_VAL and filt_out <= RST_VAL.
  - All cnt <= 0, rise_pulse and fall_pulse <= 0, so change = 0.
  - Reset has priority over every other update, including a commit due on that edge.
  - No pulse is generated by reset or by its release.
- After release, an async_in that differs from RST_VAL is processed as a normal edge. It commits and pulses STAGES+FILT_CNT edges later.

## Timing
- Edge numbering: async_in changes before edge 1 and is held.
- sync_out shows the new value after edge STAGES.
- filt_out and the pulse show it after edge STAGES+FILT_CNT. Total latency = STAGES+FILT_CNT cycles.
- Pulse width: exactly 1 cycle.
- Minimum accepted input width: FILT_CNT cycles, as seen at sync_out.
- Reset takes effect at the first rising edge with n_rst low. Outputs hold RST_VAL/0 while n_rst is low.
- Metastability: only stage[0] may go metastable. No other logic samples async_in.

## Test plan
Defaults below are WIDTH=4, STAGES=2, FILT_CNT=3, RST_VAL=4'b0000.
- Reset: hold n_rst low 2 cycles with async_in=4'hF -> sync_out, filt_out, rise_pulse and fall_pulse all 4'h0, and change=0. After release, rise_pulse=4'hF for one cycle at the 5th edge after release.
- Clean rise: async_in[0] 0->1 before edge 1 -> sync_out[0]=1 after edge 2; filt_out[0]=1, rise_pulse=4'b0001 and change=1 after edge 5 only; rise_pulse=0 after edge 6.
- Glitch reject: async_in[1] high for exactly 2 cycles -> sync_out[1] high 2 cycles, filt_out[1] stays 0, no pulses, change stays 0. A 3-cycle pulse is accepted and yields rise then fall pulses 3 cycles apart.
- Simultaneous: with filt_out=4'b0100, async_in goes to 4'b1000 in one cycle -> fall_pulse=4'b0100 and rise_pulse=4'b1000 in the same cycle, and change=1 for one cycle.
- Reset mid-filter: drive ch0 high, assert n_rst at the edge where cnt would reach 2 -> filt_out[0]=0, no pulse ever, cnt=0. After release, the commit occurs 5 edges later.
- Parameter sweep: STAGES=4, FILT_CNT=1, RST_VAL=4'hA -> outputs reset to 4'hA. A ch0 0->1 input change gives rise_pulse[0] after edge 5, and ch1 1->0 gives fall_pulse[1] after edge 5.
